word_copy: RTL and testbench

//  Memory-mapped word-copy DMA engine. CPU programs source, destination and word count

---
 rtl/word_copy_pkg.sv | 30 +++
 rtl/word_copy_if.sv | 38 +++
 rtl/word_copy_csr.sv | 60 ++++++
 rtl/word_copy.sv | 99 +++++++++
 tb/tb_word_copy.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_copy_pkg.sv
// word_copy_pkg: shared definitions for the word-copy DMA engine.
//   - copy FSM state encodings
//   - CPU-visible register indices
//   - copy configuration record (SRC/DST/COUNT)
//   - byte-address helper for the word index
package word_copy_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR      = 2'd3;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_SRC   = 4'd1;
  localparam logic [3:0] REG_DST   = 4'd2;
  localparam logic [3:0] REG_COUNT = 4'd3;

  typedef struct packed {
    logic [31:0] src;    // source byte address
    logic [31:0] dst;    // destination byte address
    logic [31:0] count;  // length in 32-bit words
  } copy_cfg_t;

  // Byte address of word idx from base; wraps mod 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/word_copy_if.sv
// word_copy_if: bundles the CPU-facing Avalon-MM slave bus and the
// memory-facing Avalon-MM master bus of the copy engine.
//   modport slave  : the engine's view (serves CPU, drives memory requests)
//   modport master : the environment's view (CPU drives requests, memory answers)
interface word_copy_if;

  // CPU -> engine register bus
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;

  // engine -> memory bus
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  modport slave (
    output slave_waitrequest, slave_readdata,
    input  slave_address, slave_read, slave_write, slave_writedata,
    input  master_waitrequest, master_readdata, master_readdatavalid,
    output master_address, master_read, master_write, master_writedata
  );

  modport master (
    input  slave_waitrequest, slave_readdata,
    output slave_address, slave_read, slave_write, slave_writedata,
    output master_waitrequest, master_readdata, master_readdatavalid,
    input  master_address, master_read, master_write, master_writedata
  );

endinterface

// File: rtl/word_copy_csr.sv
// word_copy_csr: CPU register file and slave handshake.
//   clk, rst_n    clock, async active-high reset
//   address/read/write/writedata  slave request
//   engine_idle   copy engine has no transfer in flight
//   waitrequest   combinational stall back to the CPU
//   readdata      registered read data, held until the next read
//   cfg           programmed SRC/DST/COUNT
//   start         one-cycle pulse when a CTRL write is accepted
module word_copy_csr
  import word_copy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        engine_idle,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output copy_cfg_t   cfg,
  output logic        start
);

  logic ack;
  logic accept;

  // Every access, CTRL read included, is only taken while the engine is
  // idle; the ack cycle that follows is the single low-waitrequest cycle.
  assign accept      = (read | write) & ~ack & engine_idle;
  assign waitrequest = (read | write) & ~ack;
  assign start       = accept & write & (address == REG_CTRL);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ack      <= 1'b0;
      readdata <= '0;
      cfg      <= '0;
    end else begin
      ack <= accept;
      if (accept && read) begin
        case (address)
          REG_SRC:   readdata <= cfg.src;
          REG_DST:   readdata <= cfg.dst;
          REG_COUNT: readdata <= cfg.count;
          default:   readdata <= '0;   // CTRL and unmapped read as zero
        endcase
      end
      if (accept && write) begin
        case (address)
          REG_SRC:   cfg.src   <= writedata;
          REG_DST:   cfg.dst   <= writedata;
          REG_COUNT: cfg.count <= writedata;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/word_copy.sv
// word_copy: memory-mapped word-copy DMA engine.
//   clk    single clock
//   rst_n  async reset, active-high
//   bus    word_copy_if.slave: CPU register port + memory master port
// The CPU programs SRC/DST/COUNT, writes CTRL to start, and a CTRL read
// stalls until the copy is finished. Each word is read, captured, then
// written; only one read is ever outstanding.
module word_copy
  import word_copy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  word_copy_if.slave bus
);

  logic [1:0]  state;
  copy_cfg_t   cfg;
  copy_cfg_t   work;
  logic [31:0] idx;
  logic [31:0] data_q;
  logic        start;
  logic        engine_idle;

  assign engine_idle = (state == IDLE);

  word_copy_csr u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (bus.slave_address),
    .read        (bus.slave_read),
    .write       (bus.slave_write),
    .writedata   (bus.slave_writedata),
    .engine_idle (engine_idle),
    .waitrequest (bus.slave_waitrequest),
    .readdata    (bus.slave_readdata),
    .cfg         (cfg),
    .start       (start)
  );

  // Working copy of the config is latched at start so the CPU may
  // reprogram registers without disturbing a copy (such writes stall anyway).
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= IDLE;
      work   <= '0;
      idx    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (cfg.count != 32'd0)) begin
            work  <= cfg;
            idx   <= '0;
            state <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (!bus.master_waitrequest) state <= RD_WAIT;
        end
        RD_WAIT: begin
          // readdatavalid is only meaningful here; stray pulses elsewhere
          // fall through the other states untouched.
          if (bus.master_readdatavalid) begin
            data_q <= bus.master_readdata;
            state  <= WR;
          end
        end
        WR: begin
          if (!bus.master_waitrequest) begin
            idx   <= idx + 32'd1;
            state <= ((idx + 32'd1) == work.count) ? IDLE : RD_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Master outputs decode straight from state so reset drops them at once.
  always_comb begin
    bus.master_read      = 1'b0;
    bus.master_write     = 1'b0;
    bus.master_address   = '0;
    bus.master_writedata = '0;
    case (state)
      RD_REQ: begin
        bus.master_read    = 1'b1;
        bus.master_address = word_addr(work.src, idx);
      end
      WR: begin
        bus.master_write     = 1'b1;
        bus.master_address   = word_addr(work.dst, idx);
        bus.master_writedata = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_word_copy.sv
// tb_word_copy: directed bench for word_copy. Register accesses come from a
// vector table; copy, stall, zero-count and reset scenarios are hand-written.
// A memory model answers the master port and a monitor logs transfers.
module tb_word_copy;
  import word_copy_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  word_copy_if bus ();

  word_copy dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // mode 0: never stalls, readdatavalid stuck high, data 0xFEFEFEFE
  // mode 1: random stalls, delayed valid, data = ~address, stray valids
  int          mem_mode = 0;
  bit          pending = 0;
  int          delay = 0;
  logic [31:0] pend_addr = '0;

  always @(posedge clk) begin
    #1;
    if (mem_mode == 0) begin
      bus.master_waitrequest   = 1'b0;
      bus.master_readdatavalid = 1'b1;
      bus.master_readdata      = 32'hFEFEFEFE;
    end else begin
      bus.master_waitrequest = ($urandom_range(0, 99) < 40);
      if (pending) begin
        if (delay == 0) begin
          bus.master_readdatavalid = 1'b1;
          bus.master_readdata      = ~pend_addr;
          pending = 0;
        end else begin
          delay--;
          bus.master_readdatavalid = 1'b0;
          bus.master_readdata      = 32'h0BAD0BAD;
        end
      end else begin
        bus.master_readdatavalid = ($urandom_range(0, 3) == 0);
        bus.master_readdata      = 32'hDEADBEEF;
      end
    end
  end

  // ---------------- transfer monitor ----------------
  logic [31:0] rd_q[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          last_wr_cyc = 0;
  bit          prev_rd_stall = 0, prev_wr_stall = 0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      prev_rd_stall = 0;
      prev_wr_stall = 0;
      pending = 0;
    end else begin
      if (bus.master_read || bus.master_write)
        check("rw_exclusive", {31'b0, bus.master_read & bus.master_write}, 32'd0);
      if (prev_rd_stall) begin
        check("rd_hold_req", {31'b0, bus.master_read}, 32'd1);
        check("rd_hold_addr", bus.master_address, prev_addr);
      end
      if (prev_wr_stall) begin
        check("wr_hold_req", {31'b0, bus.master_write}, 32'd1);
        check("wr_hold_addr", bus.master_address, prev_addr);
        check("wr_hold_data", bus.master_writedata, prev_data);
      end
      if (bus.master_read && !bus.master_waitrequest) begin
        check("one_outstanding", rd_q.size(), wr_a.size());
        rd_q.push_back(bus.master_address);
        pending   = 1;
        pend_addr = bus.master_address;
        delay     = $urandom_range(0, 3);
      end
      if (bus.master_write && !bus.master_waitrequest) begin
        wr_a.push_back(bus.master_address);
        wr_d.push_back(bus.master_writedata);
        last_wr_cyc = cyc;
      end
      prev_rd_stall = bus.master_read & bus.master_waitrequest;
      prev_wr_stall = bus.master_write & bus.master_waitrequest;
      prev_addr     = bus.master_address;
      prev_data     = bus.master_writedata;
    end
  end

  // ---------------- CPU access ----------------
  task automatic cpu_access(input logic [3:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output int waits, output int done_cyc);
    @(negedge clk);
    bus.slave_address   = a;
    bus.slave_read      = ~w;
    bus.slave_write     = w;
    bus.slave_writedata = d;
    waits = 0;
    #1;
    while (bus.slave_waitrequest && waits < 5000) begin
      waits++;
      @(negedge clk);
      #1;
    end
    if (bus.slave_waitrequest) begin
      checks++;
      failures++;
      $display("FAIL cpu_timeout: waitrequest still high after %0d cycles, required low", waits);
    end
    rd       = bus.slave_readdata;
    done_cyc = cyc;
    @(posedge clk);
    #1;
    bus.slave_read  = 1'b0;
    bus.slave_write = 1'b0;
  endtask

  task automatic clear_log();
    rd_q.delete();
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic verify_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                             input int n, input int mode);
    int bad;
    int first;
    int lim;
    logic [31:0] ra, wa, wd;
    check({name, "_reads"}, rd_q.size(), n);
    check({name, "_writes"}, wr_a.size(), n);
    bad = 0;
    first = -1;
    lim = (rd_q.size() < n) ? rd_q.size() : n;
    if (wr_a.size() < lim) lim = wr_a.size();
    for (int i = 0; i < lim; i++) begin
      ra = src + 32'(i) * 32'd4;
      wa = dst + 32'(i) * 32'd4;
      wd = (mode == 0) ? 32'hFEFEFEFE : ~ra;
      if (rd_q[i] !== ra || wr_a[i] !== wa || wr_d[i] !== wd) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check({name, "_bad_words"}, bad, 0);
    if (first >= 0)
      $display("  first bad word %0d: rd 0x%08h wr 0x%08h data 0x%08h", first,
               rd_q[first], wr_a[first], wr_d[first]);
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_waits;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [31:0] rd;
    int waits, dc, n;

    bus.slave_address = '0;
    bus.slave_read = 1'b0;
    bus.slave_write = 1'b0;
    bus.slave_writedata = '0;
    bus.master_waitrequest = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata = '0;

    vt[0] = '{4'd1,  1'b1, 32'hAAAA1110, 32'h0,        1};
    vt[1] = '{4'd2,  1'b1, 32'hBBBB2220, 32'h0,        1};
    vt[2] = '{4'd3,  1'b1, 32'h00000100, 32'h0,        1};
    vt[3] = '{4'd1,  1'b0, 32'h0,        32'hAAAA1110, 1};
    vt[4] = '{4'd2,  1'b0, 32'h0,        32'hBBBB2220, 1};
    vt[5] = '{4'd3,  1'b0, 32'h0,        32'h00000100, 1};
    vt[6] = '{4'd5,  1'b1, 32'hFFFFFFFF, 32'h0,        1};
    vt[7] = '{4'd5,  1'b0, 32'h0,        32'h0,        1};
    vt[8] = '{4'd15, 1'b0, 32'h0,        32'h0,        1};
    vt[9] = '{4'd1,  1'b0, 32'h0,        32'hAAAA1110, 1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_slave_wait", {31'b0, bus.slave_waitrequest}, 32'd0);
    check("rst_readdata", bus.slave_readdata, 32'd0);
    check("rst_master_rw", {30'b0, bus.master_read, bus.master_write}, 32'd0);
    check("rst_master_addr", bus.master_address, 32'd0);
    check("rst_master_wdata", bus.master_writedata, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // register table
    for (int i = 0; i < 10; i++) begin
      cpu_access(vt[i].addr, vt[i].wr, vt[i].wdata, rd, waits, dc);
      check($sformatf("vec%0d_waits", i), waits, vt[i].exp_waits);
      if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
    end

    // 256-word copy, CTRL read issued ten cycles after start
    mem_mode = 0;
    clear_log();
    cpu_access(REG_CTRL, 1'b1, 32'h1, rd, waits, dc);
    check("start_waits", waits, 1);
    repeat (10) @(posedge clk);
    cpu_access(REG_CTRL, 1'b0, 32'h0, rd, waits, dc);
    check("ctrl_rd_data", rd, 32'd0);
    check("ctrl_rd_release", dc - last_wr_cyc, 2);
    verify_copy("copy256", 32'hAAAA1110, 32'hBBBB2220, 256, 0);

    // random stalls, wrapping source, register write stalled by the copy
    mem_mode = 1;
    cpu_access(REG_SRC, 1'b1, 32'hFFFFFFF8, rd, waits, dc);
    cpu_access(REG_DST, 1'b1, 32'h00001000, rd, waits, dc);
    cpu_access(REG_COUNT, 1'b1, 32'd6, rd, waits, dc);
    clear_log();
    cpu_access(REG_CTRL, 1'b1, 32'h1, rd, waits, dc);
    cpu_access(REG_SRC, 1'b1, 32'h12345678, rd, waits, dc);
    check("busy_wr_stalled", {31'b0, waits >= 18}, 32'd1);
    check("busy_wr_release", dc - last_wr_cyc, 2);
    cpu_access(REG_CTRL, 1'b0, 32'h0, rd, waits, dc);
    check("idle_ctrl_waits", waits, 1);
    verify_copy("copy_rand", 32'hFFFFFFF8, 32'h00001000, 6, 1);
    cpu_access(REG_SRC, 1'b0, 32'h0, rd, waits, dc);
    check("src_after_stall", rd, 32'h12345678);
    mem_mode = 0;

    // zero-length copy
    clear_log();
    cpu_access(REG_COUNT, 1'b1, 32'd0, rd, waits, dc);
    cpu_access(REG_CTRL, 1'b1, 32'h1, rd, waits, dc);
    cpu_access(REG_CTRL, 1'b0, 32'h0, rd, waits, dc);
    check("zero_ctrl_waits", waits, 1);
    check("zero_ctrl_data", rd, 32'd0);
    repeat (5) @(posedge clk);
    check("zero_no_reads", rd_q.size(), 0);
    check("zero_no_writes", wr_a.size(), 0);

    // reset in the middle of a copy
    cpu_access(REG_COUNT, 1'b1, 32'd100, rd, waits, dc);
    clear_log();
    cpu_access(REG_CTRL, 1'b1, 32'h1, rd, waits, dc);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_master_rw", {30'b0, bus.master_read, bus.master_write}, 32'd0);
    check("midrst_master_addr", bus.master_address, 32'd0);
    n = rd_q.size();
    check("midrst_progress", {31'b0, n > 0}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    check("midrst_no_more_reads", rd_q.size(), n);
    cpu_access(REG_SRC, 1'b0, 32'h0, rd, waits, dc);
    check("midrst_src", rd, 32'd0);
    cpu_access(REG_DST, 1'b0, 32'h0, rd, waits, dc);
    check("midrst_dst", rd, 32'd0);
    cpu_access(REG_COUNT, 1'b0, 32'h0, rd, waits, dc);
    check("midrst_count", rd, 32'd0);
    cpu_access(REG_CTRL, 1'b0, 32'h0, rd, waits, dc);
    check("midrst_ctrl_waits", waits, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
